// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the core execute stage and mdu_seq.
interface mdu_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, flush, op, rs1, rs2, input busy, done, result);
  modport slave(input start, flush, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer sharing one 32-bit adder
// for operand negation, shift-add multiply, restoring divide and sign fix-up.
module mdu_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic   clk,
  input logic   rst_n,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(ITER);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, CALC, FIX_LO, FIX_HI, DONE} state_t;
  state_t          st;
  logic [XLEN-1:0] ra, rb, hi, lo, res;
  logic [XLEN-1:0] add_a, add_b, add_s, rsh, b_abs;
  logic [CW-1:0]   cnt;
  logic [2:0]      opr;
  logic            neg, cy, bsy, dn;
  logic            add_c, add_ci, is_div, sgn_a, sgn_b, take, div0, ovf, lo_sel;
  always_comb begin
    is_div = opr[2];
    sgn_a  = opr inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn_b  = opr inside {3'b001, 3'b100, 3'b110};
    lo_sel = opr inside {3'b000, 3'b100, 3'b101};
    rsh    = {hi[XLEN-2:0], lo[XLEN-1]};
    // The single shared adder; its operands depend only on the current state.
    add_a  = st == PREP_A ? ~ra :
             st == PREP_B ? ~rb :
             st == CALC   ? (is_div ? rsh : hi) :
             st == FIX_LO ? ~lo : ~hi;
    add_b  = st == CALC ? (is_div ? ~rb : ra) : '0;
    add_ci = st == CALC ? is_div : st == FIX_HI ? (is_div | cy) : 1'b1;
    {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_ci};
    take   = hi[XLEN-1] | add_c;
    b_abs  = (sgn_b & rb[XLEN-1]) ? add_s : rb;
    div0   = bus.rs2 == '0;
    ovf    = !bus.op[0] && bus.rs1 == MIN_NEG && bus.rs2 == '1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      ra  <= '0;
      rb  <= '0;
      hi  <= '0;
      lo  <= '0;
      res <= '0;
      cnt <= '0;
      opr <= '0;
      neg <= 1'b0;
      cy  <= 1'b0;
      bsy <= 1'b0;
      dn  <= 1'b0;
    end else if (bus.flush && st != IDLE) begin
      st  <= IDLE;
      bsy <= 1'b0;
      dn  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.start && !bus.flush) begin
          opr <= bus.op;
          ra  <= bus.rs1;
          rb  <= bus.rs2;
          hi  <= '0;
          lo  <= '0;
          cnt <= '0;
          bsy <= 1'b1;
          if (bus.op[2] && (div0 || ovf)) begin
            st  <= DONE;
            dn  <= 1'b1;
            res <= div0 ? (bus.op[1] ? bus.rs1 : '1) : (bus.op[1] ? '0 : MIN_NEG);
          end else st <= PREP_A;
        end
        PREP_A: begin
          neg <= sgn_a & ra[XLEN-1];
          if (sgn_a & ra[XLEN-1]) ra <= add_s;
          st  <= PREP_B;
        end
        PREP_B: begin
          rb  <= b_abs;
          lo  <= is_div ? ra : b_abs;
          neg <= opr == 3'b110 ? neg : neg ^ (sgn_b & rb[XLEN-1]);
          st  <= CALC;
        end
        CALC: begin
          if (is_div) begin
            hi <= take ? add_s : rsh;
            lo <= {lo[XLEN-2:0], take};
          end else begin
            hi <= lo[0] ? {add_c, add_s[XLEN-1:1]} : {1'b0, hi[XLEN-1:1]};
            lo <= {lo[0] ? add_s[0] : hi[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) st <= FIX_LO;
        end
        FIX_LO: begin
          if (neg) begin
            lo <= add_s;
            cy <= add_c;
          end
          st <= FIX_HI;
        end
        FIX_HI: begin
          if (neg) hi <= add_s;
          res <= lo_sel ? lo : (neg ? add_s : hi);
          dn  <= 1'b1;
          st  <= DONE;
        end
        DONE: begin
          st  <= IDLE;
          bsy <= 1'b0;
          dn  <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
  assign bus.busy   = bsy;
  assign bus.done   = dn;
  assign bus.result = res;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and randomized checks of mdu_seq against a 64-bit arithmetic model.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  mdu_if bus();
  mdu_seq dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0] p;
    int q;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 37;
  endfunction

  // Starts an op at the next edge and follows it to done; optionally re-asserts start mid-operation.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int ign_at,
                        output logic [31:0] res, output int lat, output int busy_bad);
    bus.start = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_bad = 0;
    for (int i = 1; i <= 60; i++) begin
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin lat = i; break; end
      if (i == ign_at) begin
        bus.start = 1'b1; bus.rs1 = a + 32'd1; bus.rs2 = b ^ 32'd1;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    res = bus.result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'd12345, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd7,
                               32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] want [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd14, 32'd2,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    int          lats [12] = '{37, 37, 37, 37, 37, 37, 37, 37, 1, 1, 1, 1};
    logic [31:0] res;
    int lat, bb;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], 0, res, lat, bb);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, want[i]); end
      checks++; if (lat != lats[i]) begin errors++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, lats[i]); end
      checks++; if (bb != 0) begin errors++; $display("FAIL directed_busy[%0d] low_cycles=%0d want=0", i, bb); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL directed_idle_busy[%0d] got=%b want=0", i, bus.busy); end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] res;
    int lat, bb;
    run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 10, res, lat, bb);
    checks++; if (res !== model(3'd3, 32'hDEADBEEF, 32'h12345678)) begin
      errors++; $display("FAIL ignored_start_result got=%h want=%h", res, model(3'd3, 32'hDEADBEEF, 32'h12345678)); end
    checks++; if (lat != 37) begin errors++; $display("FAIL ignored_start_latency got=%0d want=37", lat); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start_queued busy=%b want=0", bus.busy); end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, bb;
    run_op(3'd0, 32'd6, 32'd7, 0, res, lat, bb);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL flush_result got=%h want=%h", bus.result, 32'd42); end
    run_op(3'd5, 32'd1000, 32'd3, 0, res, lat, bb);
    checks++; if (res !== 32'd333) begin errors++; $display("FAIL after_flush_result got=%h want=%h", res, 32'd333); end
    checks++; if (lat != 37) begin errors++; $display("FAIL after_flush_latency got=%0d want=37", lat); end
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd2; bus.rs2 = 32'd2;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_start_priority busy=%b want=0", bus.busy); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic [2:0] op;
    int lat, bb;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: a = 32'h0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        3: a = $urandom_range(0, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = $urandom_range(1, 50);
        default: b = $urandom;
      endcase
      run_op(op, a, b, 0, res, lat, bb);
      checks++; if (res !== model(op, a, b)) begin
        errors++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, model(op, a, b)); end
      checks++; if (lat != exp_lat(op, a, b)) begin
        errors++; $display("FAIL random_latency op=%0d got=%0d want=%0d", op, lat, exp_lat(op, a, b)); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, bb;
    run_op(3'd0, 32'd9, 32'd9, 0, res, lat, bb);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1 = 32'h1000; bus.rs2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL async_reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL async_reset_result got=%h want=0", bus.result); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd5, 0, res, lat, bb);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL post_reset_result got=%h want=%h", res, 32'd15); end
    checks++; if (lat != 37) begin errors++; $display("FAIL post_reset_latency got=%0d want=37", lat); end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.rs1 = '0; bus.rs2 = '0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
